// File: rtl/truth_table_sweeper_pkg.sv
// Shared types for the truth-table sweeper: FSM state encoding and the
// settle-counter width helper.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

    function automatic int settleWidth(input int settle);
        return $clog2(settle) + 1;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Down-counter that sets how long each input code is held before sampling.
// A load takes priority over a decrement, and the count stops at zero.
module truth_table_sweeper_settle_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] loadValue_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadValue_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a combinational block through every input code in ascending order,
// captures its truth table and compares it against a latched golden table.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [2**N_IN-1:0] expect_tt_i,
    input  logic              dut_f_i,
    output logic [N_IN-1:0]   dut_in_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [2**N_IN-1:0] tt_o,
    output logic              match_o,
    output logic [N_IN:0]     err_count_o,
    output logic [N_IN-1:0]   first_err_o
);

    localparam int TW = 2**N_IN;
    localparam int CW = settleWidth(SETTLE);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN:0] LAST_IDX    = (N_IN+1)'(TW - 1);
    localparam logic [N_IN:0] ONE         = (N_IN+1)'(1);

    sweep_state_e      state_q, state_d;
    logic [N_IN:0]     idx_q, idx_d;
    logic [TW-1:0]     tt_q, tt_d;
    logic [TW-1:0]     expTt_q, expTt_d;
    logic [N_IN:0]     errCount_q, errCount_d;
    logic [N_IN-1:0]   firstErr_q, firstErr_d;
    logic              match_q, match_d;
    logic              done_q, done_d;

    logic              cntLoad;
    logic              cntDec;
    logic              cntZero;
    logic [N_IN-1:0]   code;

    assign code = idx_q[N_IN-1:0];

    truth_table_sweeper_settle_counter #(
        .WIDTH (CW)
    ) u_settle (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (cntLoad),
        .dec_i       (cntDec),
        .loadValue_i (SETTLE_LOAD),
        .zero_o      (cntZero)
    );

    // Next-state and datapath updates. The last index is tested before any
    // increment, so idx never moves past TW-1 and DONE keeps the final code.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tt_d       = tt_q;
        expTt_d    = expTt_q;
        errCount_d = errCount_q;
        firstErr_d = firstErr_q;
        match_d    = match_q;
        done_d     = 1'b0;
        cntLoad    = 1'b0;
        cntDec     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = DRIVE;
                    idx_d      = '0;
                    tt_d       = '0;
                    expTt_d    = expect_tt_i;
                    errCount_d = '0;
                    firstErr_d = '0;
                    match_d    = 1'b0;
                    cntLoad    = 1'b1;
                end
            end
            DRIVE: begin
                if (cntZero) begin
                    state_d = SAMPLE;
                end else begin
                    cntDec = 1'b1;
                end
            end
            SAMPLE: begin
                tt_d[code] = dut_f_i;
                if (dut_f_i != expTt_q[code]) begin
                    errCount_d = errCount_q + ONE;
                    if (errCount_q == '0) begin
                        firstErr_d = code;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    match_d = (tt_d == expTt_q);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + ONE;
                    cntLoad = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tt_q       <= '0;
            expTt_q    <= '0;
            errCount_q <= '0;
            firstErr_q <= '0;
            match_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tt_q       <= tt_d;
            expTt_q    <= expTt_d;
            errCount_q <= errCount_d;
            firstErr_q <= firstErr_d;
            match_q    <= match_d;
            done_q     <= done_d;
        end
    end

    assign dut_in_o    = code;
    assign busy_o      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done_o      = done_q;
    assign tt_o        = tt_q;
    assign match_o     = match_q;
    assign err_count_o = errCount_q;
    assign first_err_o = firstErr_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for the truth-table sweeper: one instance at SETTLE=2 and
// one at SETTLE=1, both driven by a reference model of the lab function.
module tb_truth_table_sweeper;

    localparam int TW = 16;

    typedef struct {
        logic [15:0] tt;
        logic        match;
        logic [4:0]  errCount;
        logic [3:0]  firstErr;
        int          latency;
    } expResult_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        startA, startB;
    logic [15:0] expectTt;
    logic        dutFA, dutFB;
    logic [3:0]  dutInA, dutInB;
    logic        busyA, busyB, doneA, doneB, matchA, matchB;
    logic [15:0] ttA, ttB;
    logic [4:0]  errA, errB;
    logic [3:0]  firstA, firstB;

    logic        useB;
    int          fSel;
    int          checks = 0;
    int          errors = 0;
    expResult_t  sbQ[$];

    logic        obsBusy, obsDone, obsMatch;
    logic [3:0]  obsDutIn, obsFirst;
    logic [15:0] obsTt;
    logic [4:0]  obsErr;

    always #5 clk = ~clk;

    function automatic logic fModel(input int sel, input logic [3:0] c);
        if (sel == 0) return (c[3] & c[2]) | (c[1] & c[0]);
        return 1'b0;
    endfunction

    assign dutFA = fModel(fSel, dutInA);
    assign dutFB = fModel(fSel, dutInB);

    assign obsBusy  = useB ? busyB  : busyA;
    assign obsDone  = useB ? doneB  : doneA;
    assign obsMatch = useB ? matchB : matchA;
    assign obsDutIn = useB ? dutInB : dutInA;
    assign obsFirst = useB ? firstB : firstA;
    assign obsTt    = useB ? ttB    : ttA;
    assign obsErr   = useB ? errB   : errA;

    truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dutA (
        .clk_i(clk), .rst_i(rst), .start_i(startA), .expect_tt_i(expectTt),
        .dut_f_i(dutFA), .dut_in_o(dutInA), .busy_o(busyA), .done_o(doneA),
        .tt_o(ttA), .match_o(matchA), .err_count_o(errA), .first_err_o(firstA)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dutB (
        .clk_i(clk), .rst_i(rst), .start_i(startB), .expect_tt_i(expectTt),
        .dut_f_i(dutFB), .dut_in_o(dutInB), .busy_o(busyB), .done_o(doneB),
        .tt_o(ttB), .match_o(matchB), .err_count_o(errB), .first_err_o(firstB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep; restartAt re-pulses start mid-sweep, rstAt aborts with reset.
    task automatic applyStimulus(input logic selB, input int sel,
                                 input logic [15:0] expT, input int restartAt,
                                 input int rstAt);
        expResult_t e;
        int settle;
        int cyc;
        bit finished;
        bit sawDone;
        logic bitF;

        useB   = selB;
        fSel   = sel;
        settle = selB ? 1 : 2;

        e.tt       = '0;
        e.errCount = '0;
        e.firstErr = '0;
        for (int i = 0; i < TW; i++) begin
            bitF = fModel(sel, 4'(i));
            e.tt[i] = bitF;
            if (bitF != expT[i]) begin
                if (e.errCount == 0) e.firstErr = 4'(i);
                e.errCount = e.errCount + 5'd1;
            end
        end
        e.match   = (e.errCount == 0);
        e.latency = TW * (settle + 1) + 1;
        sbQ.push_back(e);

        @(negedge clk);
        expectTt = expT;
        if (selB) startB = 1'b1; else startA = 1'b1;
        @(negedge clk);
        startA   = 1'b0;
        startB   = 1'b0;
        cyc      = 1;
        finished = 1'b0;
        sawDone  = 1'b0;

        while (!finished && cyc <= 200) begin
            if (cyc == 5) expectTt = ~expT;
            startA = !selB && (cyc == restartAt);
            startB = selB && (cyc == restartAt);
            if (rstAt != 0 && cyc == rstAt) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("abortBusy", obsBusy, 1'b0);
                checkOutput("abortTt", obsTt, 16'h0);
                checkOutput("abortErr", obsErr, 5'd0);
                checkOutput("abortDutIn", obsDutIn, 4'd0);
                checkOutput("abortMatch", obsMatch, 1'b0);
                sbQ.delete();
                finished = 1'b1;
            end else if (obsDone) begin
                if (sbQ.size() == 0) begin
                    checkOutput("scoreboardEmpty", 1'b0, 1'b1);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("latency", cyc, e.latency);
                    checkOutput("tt", obsTt, e.tt);
                    checkOutput("match", obsMatch, e.match);
                    checkOutput("errCount", obsErr, e.errCount);
                    checkOutput("firstErr", obsFirst, e.firstErr);
                    checkOutput("busyAtDone", obsBusy, 1'b0);
                    checkOutput("dutInAtDone", obsDutIn, 4'd15);
                end
                finished = 1'b1;
                sawDone  = 1'b1;
            end else begin
                checkOutput("busy", obsBusy, 1'b1);
                checkOutput("dutIn", obsDutIn, (cyc - 1) / (settle + 1));
                checkOutput("matchMid", obsMatch, 1'b0);
                @(negedge clk);
                cyc++;
            end
        end
        startA = 1'b0;
        startB = 1'b0;
        if (!finished) begin
            checkOutput("doneTimeout", 1'b0, 1'b1);
            sbQ.delete();
        end
        if (sawDone) begin
            @(negedge clk);
            checkOutput("donePulseEnd", obsDone, 1'b0);
            checkOutput("holdTt", obsTt, e.tt);
            checkOutput("holdMatch", obsMatch, e.match);
            checkOutput("holdDutIn", obsDutIn, 4'd15);
        end
    endtask

    initial begin
        rst      = 1'b1;
        startA   = 1'b1;
        startB   = 1'b1;
        expectTt = 16'hFFFF;
        fSel     = 0;
        useB     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", busyA, 1'b0);
        checkOutput("rstDone", doneA, 1'b0);
        checkOutput("rstTt", ttA, 16'h0);
        checkOutput("rstMatch", matchA, 1'b0);
        checkOutput("rstErr", errA, 5'd0);
        checkOutput("rstFirst", firstA, 4'd0);
        checkOutput("rstDutIn", dutInA, 4'd0);
        rst    = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        @(negedge clk);
        checkOutput("rstStartIgnoredA", busyA, 1'b0);
        checkOutput("rstStartIgnoredB", busyB, 1'b0);

        applyStimulus(1'b0, 0, 16'hF888, 0, 0);
        applyStimulus(1'b0, 0, 16'hF889, 0, 0);
        applyStimulus(1'b0, 0, 16'h7888, 0, 0);
        applyStimulus(1'b0, 1, 16'hFFFF, 0, 0);
        applyStimulus(1'b0, 0, 16'hF888, 10, 0);
        applyStimulus(1'b0, 0, 16'hF888, 10, 20);
        applyStimulus(1'b0, 0, 16'hF888, 0, 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 0, 16'($urandom), 0, 0);
        end
        applyStimulus(1'b1, 0, 16'hF888, 0, 0);
        applyStimulus(1'b1, 1, 16'h0100, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
